// File: rtl/msg_event_collector.sv
// -----------------------------------------------------------------------------
// msg_event_collector
//
// Purpose:
//   Collects typed message events that monitors, checkers and BFMs raise during
//   simulation. Each accepted event is timestamped and counted by type. It is
//   enqueued for a drain agent only when its severity reaches the current
//   threshold. STOP and EXIT actions become request flags for the bench top
//   level.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   evt_valid/ready   event handshake; transfer when both are high
//   evt_src/code      source ID and message code of the offered event
//   evt_type          0 INFO, 1 WARN, 2 ERROR, 3 FATAL
//   evt_svrt          0 LOW, 1 MEDIUM, 2 HIGH, 3 HIGHEST
//   evt_act           0 LOG, 1 STOP, 2 EXIT, 3 reserved (behaves as LOG)
//   svrt_thold        minimum severity that is enqueued
//   clr_cnt           pulse: clear all per-type counters
//   resume            pulse: leave STOPPED
//   rec_valid/ready   record FIFO head handshake; pop when both are high
//   rec_data          head record {ts, type, svrt, src, code}
//   stop_req          high while STOPPED
//   exit_req          high in DONE (terminal until reset)
//   cnt_*             saturating accepted-event counts per type
//   fifo_level        current record FIFO occupancy
// -----------------------------------------------------------------------------
module msg_event_collector #(
    parameter int FIFO_DEPTH = 8,
    parameter int SRC_W      = 4,
    parameter int CODE_W     = 16,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            evt_valid,
    output logic                            evt_ready,
    input  logic [SRC_W-1:0]                evt_src,
    input  logic [CODE_W-1:0]               evt_code,
    input  logic [1:0]                      evt_type,
    input  logic [1:0]                      evt_svrt,
    input  logic [1:0]                      evt_act,
    input  logic [1:0]                      svrt_thold,
    input  logic                            clr_cnt,
    input  logic                            resume,
    output logic                            rec_valid,
    input  logic                            rec_ready,
    output logic [TS_W+SRC_W+CODE_W+3:0]    rec_data,
    output logic                            stop_req,
    output logic                            exit_req,
    output logic [CNT_W-1:0]                cnt_info,
    output logic [CNT_W-1:0]                cnt_warn,
    output logic [CNT_W-1:0]                cnt_error,
    output logic [CNT_W-1:0]                cnt_fatal,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int REC_W = TS_W + SRC_W + CODE_W + 4;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STOPPED = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [1:0] ACT_STOP = 2'd1;
    localparam logic [1:0] ACT_EXIT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic                   ready_en_q;
    logic [TS_W-1:0]        ts_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [REC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [3:0][CNT_W-1:0]  cnt_vec;

    logic accept;
    logic push;
    logic pop;

    // ready_en_q holds evt_ready low while in reset and releases it on the
    // first clock edge after rst_n deasserts. Everything here is registered,
    // so a pop in the same cycle can never unblock a full FIFO.
    assign evt_ready = ready_en_q && (state_q == ST_RUN) && (level_q < FULL_LVL);
    assign accept    = evt_valid && evt_ready;
    assign push      = accept && (evt_svrt >= svrt_thold);
    assign rec_valid = (level_q != '0);
    assign pop       = rec_valid && rec_ready;
    assign rec_data  = mem_q[rd_ptr_q];

    assign stop_req   = (state_q == ST_STOPPED);
    assign exit_req   = (state_q == ST_DONE);
    assign fifo_level = level_q;

    assign cnt_info  = cnt_vec[0];
    assign cnt_warn  = cnt_vec[1];
    assign cnt_error = cnt_vec[2];
    assign cnt_fatal = cnt_vec[3];

    // Control FSM; the reserved action code falls through as LOG.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (evt_act == ACT_STOP) begin
                        state_d = ST_STOPPED;
                    end else if (evt_act == ACT_EXIT) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_STOPPED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (level_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ready_en_q <= 1'b0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            ts_q       <= ts_q + 1'b1;
            level_q    <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Record storage needs no reset: only entries below level_q are visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, evt_type, evt_svrt, evt_src, evt_code};
        end
    end

    // Per-type saturating counters. A clear that coincides with an accept
    // leaves the accepted type at 1, so the event is never lost.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = clr_cnt ? '0 : cnt_q;
                if (accept && (evt_type == 2'(gi))) begin
                    if (clr_cnt) begin
                        cnt_d = CNT_ONE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_msg_event_collector.sv
`timescale 1ns/1ps
module tb_msg_event_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_src;
    logic [15:0] evt_code;
    logic [1:0]  evt_type;
    logic [1:0]  evt_svrt;
    logic [1:0]  evt_act;
    logic [1:0]  svrt_thold;
    logic        clr_cnt;
    logic        resume;
    logic        rec_valid;
    logic        rec_ready;
    logic [55:0] rec_data;
    logic        stop_req;
    logic        exit_req;
    logic [15:0] cnt_info;
    logic [15:0] cnt_warn;
    logic [15:0] cnt_error;
    logic [15:0] cnt_fatal;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [55:0] exp_q [$];
    logic [31:0] cyc;

    always #5 clk = ~clk;

    msg_event_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_src    (evt_src),
        .evt_code   (evt_code),
        .evt_type   (evt_type),
        .evt_svrt   (evt_svrt),
        .evt_act    (evt_act),
        .svrt_thold (svrt_thold),
        .clr_cnt    (clr_cnt),
        .resume     (resume),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .stop_req   (stop_req),
        .exit_req   (exit_req),
        .cnt_info   (cnt_info),
        .cnt_warn   (cnt_warn),
        .cnt_error  (cnt_error),
        .cnt_fatal  (cnt_fatal),
        .fifo_level (fifo_level)
    );

    // Reference timestamp: cycles elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer one event, wait (bounded) for acceptance, push the expected record
    // if it should be enqueued. Returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] src, input logic [15:0] code,
                        input logic [1:0] typ, input logic [1:0] svrt,
                        input logic [1:0] act, input bit exp_push);
        int waited;
        evt_valid = 1'b1;
        evt_src   = src;
        evt_code  = code;
        evt_type  = typ;
        evt_svrt  = svrt;
        evt_act   = act;
        waited    = 0;
        while (!evt_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!evt_ready) begin
            check("send_timeout", 64'(evt_ready), 64'd1);
        end else begin
            if (exp_push) exp_q.push_back({cyc, typ, svrt, src, code});
            $display("evt src=%0d code=%h type=%0d svrt=%0d act=%0d ts=%0d push=%0d",
                     src, code, typ, svrt, act, cyc, exp_push);
            tick();
        end
        evt_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare every popped record against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rec_unexpected", 64'(rec_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [55:0] e;
                    e = exp_q.pop_front();
                    $display("rec pop data=%h", rec_data);
                    check("rec_data", 64'(rec_data), 64'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; evt_valid = 1'b0; evt_src = '0; evt_code = '0;
        evt_type = '0; evt_svrt = '0; evt_act = '0; svrt_thold = 2'd0;
        clr_cnt = 1'b0; resume = 1'b0; rec_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("ready_in_reset", 64'(evt_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 64'(evt_ready), 64'd1);
        check("rec_valid_rst",   64'(rec_valid), 64'd0);
        check("cnts_rst", {cnt_info, cnt_warn, cnt_error, cnt_fatal}, 64'd0);
        check("flags_rst", {62'd0, stop_req, exit_req}, 64'd0);

        // Basic record at ts=10
        svrt_thold = 2'd1;
        while (cyc < 10) tick();
        send(4'd3, 16'h00A5, 2'd1, 2'd2, 2'd0, 1'b1);
        check("rec_valid_lat1", 64'(rec_valid), 64'd1);
        check("rec_data_ts10",  64'(rec_data), 64'h0000_000A_6300A5);
        check("cnt_warn_1",     64'(cnt_warn), 64'd1);
        tick();

        // Severity filtering
        rec_ready  = 1'b0;
        svrt_thold = 2'd2;
        send(4'd1, 16'h1111, 2'd0, 2'd0, 2'd0, 1'b0);
        send(4'd2, 16'h2222, 2'd2, 2'd3, 2'd0, 1'b1);
        check("cnt_info_1",  64'(cnt_info),   64'd1);
        check("cnt_error_1", 64'(cnt_error),  64'd1);
        check("level_1",     64'(fifo_level), 64'd1);
        rec_ready = 1'b1;
        tick(); tick();
        rec_ready = 1'b0;
        check("level_0a", 64'(fifo_level), 64'd0);

        // Fill to full, pop while full blocks accept, next cycle accepts
        for (int i = 0; i < 8; i++) begin
            send(4'(i), 16'h3000 + 16'(i), 2'd0, 2'd2, (i == 5) ? 2'd3 : 2'd0, 1'b1);
        end
        check("level_full",     64'(fifo_level), 64'd8);
        check("ready_full",     64'(evt_ready),  64'd0);
        evt_valid = 1'b1; evt_src = 4'd9; evt_code = 16'h3009;
        evt_type = 2'd0; evt_svrt = 2'd2; evt_act = 2'd0;
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        check("level_after_pop", 64'(fifo_level), 64'd7);
        check("ready_after_pop", 64'(evt_ready),  64'd1);
        exp_q.push_back({cyc, 2'd0, 2'd2, 4'd9, 16'h3009});
        tick();
        evt_valid = 1'b0;
        check("level_refill", 64'(fifo_level), 64'd8);
        check("cnt_info_10",  64'(cnt_info),   64'd10);
        rec_ready = 1'b1;
        k = 0;
        while (fifo_level != 0 && k < 30) begin tick(); k++; end
        check("level_drained", 64'(fifo_level), 64'd0);

        // STOP / resume
        resume = 1'b1; tick(); resume = 1'b0;
        check("resume_ignored", {62'd0, stop_req, evt_ready}, 64'd1);
        send(4'd4, 16'h4444, 2'd1, 2'd2, 2'd1, 1'b1);
        check("stop_req_set",  64'(stop_req),  64'd1);
        check("ready_stopped", 64'(evt_ready), 64'd0);
        tick(); tick();
        check("stop_drained",  64'(fifo_level), 64'd0);
        resume = 1'b1; tick(); resume = 1'b0;
        check("stop_req_clr",  64'(stop_req),  64'd0);
        check("ready_resumed", 64'(evt_ready), 64'd1);
        check("cnt_warn_2",    64'(cnt_warn),  64'd2);

        // EXIT with 3 queued records
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd5, 16'h5000 + 16'(i), 2'd2, 2'd2, 2'd0, 1'b1);
        send(4'd6, 16'h6666, 2'd2, 2'd3, 2'd2, 1'b1);
        check("ready_drain", 64'(evt_ready),  64'd0);
        check("level_4",     64'(fifo_level), 64'd4);
        evt_valid = 1'b1; evt_src = 4'd7; evt_code = 16'h7777;
        evt_type = 2'd0; evt_svrt = 2'd3; evt_act = 2'd0;
        rec_ready = 1'b1;
        k = 0;
        while (fifo_level != 0 && k < 30) begin tick(); k++; end
        check("drain_empty",  64'(fifo_level), 64'd0);
        check("exit_not_yet", 64'(exit_req),   64'd0);
        tick();
        check("exit_req_set", 64'(exit_req),   64'd1);
        repeat (3) tick();
        check("ready_done",   64'(evt_ready),  64'd0);
        check("exit_sticky",  64'(exit_req),   64'd1);
        check("cnt_info_kept", 64'(cnt_info),  64'd10);
        check("cnt_error_5",  64'(cnt_error),  64'd5);
        evt_valid = 1'b0;
        check("sb_empty_1",   64'(exp_q.size()), 64'd0);

        // Reset mid-operation clears flags immediately
        rst_n = 1'b0;
        #1;
        check("exit_clr_rst", 64'(exit_req),  64'd0);
        check("cnt_clr_rst",  64'(cnt_error), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_rst2", 64'(evt_ready), 64'd1);

        // Saturation and clr_cnt with simultaneous accept
        svrt_thold = 2'd3;
        evt_valid = 1'b1; evt_src = 4'd1; evt_code = 16'h0001;
        evt_type = 2'd0; evt_svrt = 2'd0; evt_act = 2'd0;
        tick();
        evt_type = 2'd3;
        repeat (65535) tick();
        check("cnt_fatal_max",  64'(cnt_fatal),  64'hFFFF);
        check("cnt_info_one",   64'(cnt_info),   64'd1);
        check("level_nopush",   64'(fifo_level), 64'd0);
        tick();
        check("cnt_fatal_sat",  64'(cnt_fatal),  64'hFFFF);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; evt_valid = 1'b0;
        check("clr_fatal_1",    64'(cnt_fatal),  64'd1);
        check("clr_others",     {16'd0, cnt_info, cnt_warn, cnt_error}, 64'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_fatal_0",    64'(cnt_fatal),  64'd0);
        check("sb_empty_end",   64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
